// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential RV32I ALU: operation codes, FSM states
// and the shift-class helper.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_seq_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between execute and the sequential ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] data_1_i;
  logic [XLEN-1:0] data_2_i;
  alu_op_t         alu_op_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] alu_result_o;
  logic            zero_o;
  logic            busy_o;

  modport slave (
    input  valid_i, data_1_i, data_2_i, alu_op_i, ready_i,
    output ready_o, valid_o, alu_result_o, zero_o, busy_o
  );

  modport master (
    output valid_i, data_1_i, data_2_i, alu_op_i, ready_i,
    input  ready_o, valid_o, alu_result_o, zero_o, busy_o
  );

endinterface

// File: rtl/alu_seq_shift_iter.sv
// Iterative shifter: moves at most SHIFT_STEP bit positions per cycle so the
// shift network stays bounded; done_o flags the cycle producing the final value.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  alu_op_t                  op_i,
  input  logic [XLEN-1:0]          value_i,
  input  logic [$clog2(XLEN)-1:0]  amount_i,
  output logic                     done_o,
  output logic [XLEN-1:0]          result_o
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP_MAX = (SHW + 1)'(SHIFT_STEP);

  logic [XLEN-1:0] val_q, val_d, shifted;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [SHW:0]    step;
  alu_op_t         op_q, op_d;
  logic            active_q, active_d;

  // Distance for this iteration: min(SHIFT_STEP, remaining).
  always_comb begin
    step = {1'b0, rem_q};
    if ({1'b0, rem_q} > STEP_MAX) begin
      step = STEP_MAX;
    end else begin
      step = {1'b0, rem_q};
    end
  end

  // One bounded shift step; SRA re-reads the current MSB so sign fill holds.
  always_comb begin
    shifted = val_q;
    case (op_q)
      ALU_SLL: shifted = val_q << step;
      ALU_SRL: shifted = val_q >> step;
      ALU_SRA: shifted = $unsigned($signed(val_q) >>> step);
      default: shifted = val_q;
    endcase
  end

  assign done_o   = active_q && ({1'b0, rem_q} <= STEP_MAX);
  assign result_o = shifted;

  // Load on start, otherwise iterate until the remaining count is exhausted.
  always_comb begin
    val_d    = val_q;
    rem_d    = rem_q;
    op_d     = op_q;
    active_d = active_q;
    if (start_i) begin
      val_d    = value_i;
      rem_d    = amount_i;
      op_d     = op_i;
      active_d = 1'b1;
    end else if (active_q) begin
      val_d    = shifted;
      rem_d    = rem_q - step[SHW-1:0];
      active_d = !done_o;
    end else begin
      active_d = 1'b0;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      val_q    <= {XLEN{1'b0}};
      rem_q    <= {SHW{1'b0}};
      op_q     <= ALU_SLL;
      active_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered RV32I ALU. Non-shift ops complete in one cycle;
// non-zero shifts are handed to the iterative shifter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  alu_seq_state_t  state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] shift_result;
  logic [SHW-1:0]  amount;
  logic            ready, accept, start_shift, shift_done;

  // Single-cycle datapath; shifts by zero and undefined codes pass A through.
  function automatic logic [XLEN-1:0] calc(input alu_op_t op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      default:  return a;
    endcase
  endfunction

  assign amount = bus.data_2_i[SHW-1:0];
  assign ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ready_i);
  assign accept = bus.valid_i && ready;

  // Next-state logic; an accept in DONE re-enters the IDLE launch path.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    start_shift = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_BUSY: begin
        if (shift_done) begin
          result_d = shift_result;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (is_shift(bus.alu_op_i) && (amount != {SHW{1'b0}})) begin
        start_shift = 1'b1;
        state_d     = ST_BUSY;
      end else begin
        result_d = calc(bus.alu_op_i, bus.data_1_i, bus.data_2_i);
        state_d  = ST_DONE;
      end
    end else begin
      start_shift = 1'b0;
    end
  end

  // FSM and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  alu_shift_iter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_shift),
    .op_i     (bus.alu_op_i),
    .value_i  (bus.data_1_i),
    .amount_i (amount),
    .done_o   (shift_done),
    .result_o (shift_result)
  );

  assign bus.ready_o      = ready;
  assign bus.valid_o      = (state_q == ST_DONE);
  assign bus.busy_o       = (state_q == ST_BUSY);
  assign bus.alu_result_o = result_q;
  assign bus.zero_o       = (result_q == {XLEN{1'b0}});

endmodule
